// File: rtl/aud_pkg.sv
// -----------------------------------------------------------------------------
// aud_pkg
// Shared definitions for the audio resampler slice: default widths, the
// playback state encoding and the fixed-point "1.0" helper.
// -----------------------------------------------------------------------------
package aud_pkg;

  localparam int unsigned SAMPLE_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF   = 20;
  localparam int unsigned CH_DEF       = 2;
  localparam int unsigned FRAC_W_DEF   = 8;
  localparam int unsigned INT_W_DEF    = 3;
  localparam int unsigned SRAM_LAT_DEF = 1;

  // Playback sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PAUSE   = 3'd1,
    ST_WAIT_LR = 3'd2,
    ST_FETCH   = 3'd3,
    ST_INTERP  = 3'd4
  } aud_state_e;

  // Unity step / phase increment for a given number of fractional bits
  function automatic logic [31:0] one_q(input int unsigned frac_w);
    one_q = 32'd1 << frac_w;
  endfunction

endpackage

// File: rtl/aud_lerp.sv
// -----------------------------------------------------------------------------
// aud_lerp
// One registered linear-interpolation stage:
//   sample = A + (((B - A) * frac) >>> FRAC_W)   (floor), or A when hold_i.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   a_i, b_i       : signed samples of the two neighbouring frames
//   frac_i         : unsigned fractional position between A and B
//   hold_i         : 1 = output A unchanged
//   sample_o       : registered result
// -----------------------------------------------------------------------------
module aud_lerp #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned FRAC_W   = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [SAMPLE_W-1:0] a_i,
  input  logic [SAMPLE_W-1:0] b_i,
  input  logic [FRAC_W-1:0]   frac_i,
  input  logic                hold_i,
  output logic [SAMPLE_W-1:0] sample_o
);

  localparam int unsigned P_W = SAMPLE_W + FRAC_W + 2;

  logic [SAMPLE_W:0]         diff;
  logic signed [P_W-1:0]     prod;
  logic signed [P_W-1:0]     delta;
  logic [P_W-1:0]            sum_v;
  logic [SAMPLE_W-1:0]       sample_d;
  logic [SAMPLE_W-1:0]       sample_q;
  logic                      unused_hi;

  // Interpolation arithmetic; the low P_W bits of the two's-complement
  // product are exact, so the operands are simply extended to full width.
  always_comb begin
    diff  = {b_i[SAMPLE_W-1], b_i} - {a_i[SAMPLE_W-1], a_i};
    prod  = {{(FRAC_W+1){diff[SAMPLE_W]}}, diff} * {{(P_W-FRAC_W){1'b0}}, frac_i};
    delta = prod >>> FRAC_W;
    sum_v = {{(P_W-SAMPLE_W){a_i[SAMPLE_W-1]}}, a_i} + delta;
    if (hold_i) begin
      sample_d = a_i;
    end else begin
      // result lies between A and B, so the upper bits are pure sign
      sample_d = sum_v[SAMPLE_W-1:0];
    end
  end

  assign unused_hi = ^sum_v[P_W-1:SAMPLE_W];

  // Output register of the interpolation stage
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sample_q <= '0;
    end else begin
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/aud_resampler.sv
// -----------------------------------------------------------------------------
// aud_resampler
// N-channel playback resampler between the SRAM reader and the DAC player.
// A fractional phase accumulator walks interleaved frames inside a
// [start, stop] address window (forward or reverse, loop or one-shot). On
// every DAC LR rising edge it fetches frames idx and idx+1 for every channel,
// interpolates (or holds) and updates all channels at once.
// Ports:
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_start / i_stop / i_pause: control pulses (stop > start > pause)
//   i_step                    : Q(INT_W.FRAC_W) playback rate
//   i_interp/i_reverse/i_loop : mode bits, latched at each LR edge
//   i_daclrck                 : DAC LR clock, rising edge = frame boundary
//   i_sram_data, o_sram_addr  : SRAM read port (SRAM_LAT cycles latency)
//   i_start_addr/i_stop_addr  : inclusive sample window
//   o_dac_data                : CH samples, ch0 in the LSBs
//   o_en                      : !i_daclrck
//   o_is_pause/o_busy/o_done  : status
// -----------------------------------------------------------------------------
module aud_resampler
  import aud_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned CH       = CH_DEF,
  parameter int unsigned FRAC_W   = FRAC_W_DEF,
  parameter int unsigned INT_W    = INT_W_DEF,
  parameter int unsigned SRAM_LAT = SRAM_LAT_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic                     i_pause,
  input  logic [INT_W+FRAC_W-1:0]  i_step,
  input  logic                     i_interp,
  input  logic                     i_reverse,
  input  logic                     i_loop,
  input  logic                     i_daclrck,
  input  logic [SAMPLE_W-1:0]      i_sram_data,
  input  logic [ADDR_W-1:0]        i_start_addr,
  input  logic [ADDR_W-1:0]        i_stop_addr,
  output logic [ADDR_W-1:0]        o_sram_addr,
  output logic [CH*SAMPLE_W-1:0]   o_dac_data,
  output logic                     o_en,
  output logic                     o_is_pause,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int unsigned PH_W   = ADDR_W + FRAC_W;
  localparam int unsigned PHX_W  = PH_W + 1;
  localparam int unsigned STEP_W = INT_W + FRAC_W;
  localparam int unsigned NF_W   = ADDR_W + 1;
  localparam int unsigned CH_W   = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned LAT_W  = (SRAM_LAT > 0) ? $clog2(SRAM_LAT + 1) : 1;

  aud_state_e              state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [CH*SAMPLE_W-1:0]  out_q, out_d;
  logic [STEP_W-1:0]       step_q, step_d;
  logic                    interp_q, interp_d;
  logic                    reverse_q, reverse_d;
  logic                    loop_q, loop_d;
  logic                    lrck_q;
  logic                    is_pause_q, is_pause_d;
  logic                    done_q, done_d;
  logic                    pend_q, pend_d;     // pause requested mid-frame
  logic                    end_q, end_d;       // one-shot end reached
  logic [CH_W-1:0]         fch_q, fch_d;       // channel being fetched
  logic                    fb_q, fb_d;         // 0 = reading A, 1 = reading B
  logic                    icyc_q, icyc_d;     // INTERP sub-cycle
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic [SAMPLE_W-1:0]     a_q [CH];
  logic [SAMPLE_W-1:0]     a_d [CH];
  logic [SAMPLE_W-1:0]     b_q [CH];
  logic [SAMPLE_W-1:0]     b_d [CH];
  logic [SAMPLE_W-1:0]     lerp_out [CH];

  logic [NF_W-1:0]         win_len;
  logic [NF_W-1:0]         nframes;
  logic [ADDR_W-1:0]       idx;
  logic [ADDR_W-1:0]       b_idx;
  logic                    last_frame;
  logic [PHX_W-1:0]        ph_ext, step_ext, nf_fix, ph_wrap;
  logic                    ph_end;
  logic                    lr_rise;
  logic                    pend_eff;
  logic                    unused_ph;

  // Word address of channel ch of frame `frame` inside the window
  function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] base,
                                                input logic [ADDR_W-1:0] frame,
                                                input logic [CH_W-1:0]   ch);
    rd_addr = base + frame * ADDR_W'(CH) + ADDR_W'(ch);
  endfunction

  // Window geometry, neighbour frame selection and next phase
  always_comb begin
    win_len    = {1'b0, i_stop_addr} - {1'b0, i_start_addr} + NF_W'(1);
    nframes    = win_len / NF_W'(CH);
    idx        = phase_q[PH_W-1:FRAC_W];
    last_frame = ({1'b0, idx} == (nframes - NF_W'(1)));
    if (last_frame || !interp_q) begin
      b_idx = idx;
    end else begin
      b_idx = idx + ADDR_W'(1);
    end
    ph_ext   = {1'b0, phase_q};
    step_ext = PHX_W'(step_q);
    nf_fix   = {nframes, {FRAC_W{1'b0}}};
    ph_end   = 1'b0;
    if (!reverse_q) begin
      ph_wrap = ph_ext + step_ext;
      if (ph_wrap >= nf_fix) begin
        ph_wrap = ph_wrap - nf_fix;
        ph_end  = !loop_q;
      end else begin
        ph_end  = 1'b0;
      end
    end else begin
      if (ph_ext < step_ext) begin
        ph_wrap = ph_ext + nf_fix - step_ext;
        ph_end  = !loop_q;
      end else begin
        ph_wrap = ph_ext - step_ext;
        ph_end  = 1'b0;
      end
    end
  end

  assign unused_ph = ph_wrap[PH_W];
  assign lr_rise   = i_daclrck & ~lrck_q;

  // Sequencer: next state and all register next values
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    addr_d     = addr_q;
    out_d      = out_q;
    step_d     = step_q;
    interp_d   = interp_q;
    reverse_d  = reverse_q;
    loop_d     = loop_q;
    is_pause_d = is_pause_q;
    done_d     = 1'b0;
    pend_d     = pend_q;
    end_d      = end_q;
    fch_d      = fch_q;
    fb_d       = fb_q;
    icyc_d     = icyc_q;
    lat_d      = lat_q;
    a_d        = a_q;
    b_d        = b_q;
    pend_eff   = pend_q;

    if (i_stop) begin
      state_d    = ST_IDLE;
      phase_d    = '0;
      addr_d     = '0;
      out_d      = '0;
      is_pause_d = 1'b1;
      pend_d     = 1'b0;
      end_d      = 1'b0;
    end else if (i_start) begin
      state_d    = ST_PAUSE;
      phase_d    = '0;
      out_d      = '0;
      is_pause_d = 1'b1;
      pend_d     = 1'b0;
      end_d      = 1'b0;
    end else begin
      // a pause arriving mid-frame is deferred until the frame is done
      if ((state_q == ST_FETCH) || (state_q == ST_INTERP)) begin
        pend_eff = pend_q ^ i_pause;
      end else begin
        pend_eff = pend_q;
      end
      pend_d = pend_eff;

      case (state_q)
        ST_IDLE: begin
          out_d = '0;
        end
        ST_PAUSE: begin
          out_d = '0;
          if (i_pause) begin
            is_pause_d = 1'b0;
            state_d    = ST_WAIT_LR;
          end else begin
            is_pause_d = 1'b1;
          end
        end
        ST_WAIT_LR: begin
          if (end_q) begin
            done_d     = 1'b1;
            end_d      = 1'b0;
            state_d    = ST_IDLE;
            out_d      = '0;
            addr_d     = '0;
            is_pause_d = 1'b1;
          end else if (i_pause) begin
            is_pause_d = 1'b1;
            state_d    = ST_PAUSE;
          end else if (lr_rise) begin
            step_d    = i_step;
            interp_d  = i_interp;
            reverse_d = i_reverse;
            loop_d    = i_loop;
            fch_d     = '0;
            fb_d      = 1'b0;
            lat_d     = '0;
            addr_d    = rd_addr(i_start_addr, idx, '0);
            state_d   = ST_FETCH;
          end else begin
            state_d = ST_WAIT_LR;
          end
        end
        ST_FETCH: begin
          if (lat_q == LAT_W'(SRAM_LAT)) begin
            lat_d = '0;
            if (!fb_q) begin
              a_d[fch_q] = i_sram_data;
              fb_d       = 1'b1;
              addr_d     = rd_addr(i_start_addr, b_idx, fch_q);
            end else begin
              b_d[fch_q] = i_sram_data;
              if (fch_q == CH_W'(CH - 1)) begin
                icyc_d  = 1'b0;
                state_d = ST_INTERP;
              end else begin
                fch_d  = fch_q + CH_W'(1);
                fb_d   = 1'b0;
                addr_d = rd_addr(i_start_addr, idx, fch_q + CH_W'(1));
              end
            end
          end else begin
            lat_d = lat_q + LAT_W'(1);
          end
        end
        ST_INTERP: begin
          if (!icyc_q) begin
            // lerp stage registers its result during this cycle
            icyc_d = 1'b1;
          end else begin
            for (int c = 0; c < CH; c++) begin
              out_d[c*SAMPLE_W +: SAMPLE_W] = lerp_out[c];
            end
            if (ph_end) begin
              end_d   = 1'b1;
              pend_d  = 1'b0;
              state_d = ST_WAIT_LR;
            end else if (pend_eff) begin
              phase_d    = ph_wrap[PH_W-1:0];
              pend_d     = 1'b0;
              is_pause_d = 1'b1;
              state_d    = ST_PAUSE;
            end else begin
              phase_d = ph_wrap[PH_W-1:0];
              state_d = ST_WAIT_LR;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      addr_q     <= '0;
      out_q      <= '0;
      step_q     <= '0;
      interp_q   <= 1'b0;
      reverse_q  <= 1'b0;
      loop_q     <= 1'b0;
      lrck_q     <= 1'b0;
      is_pause_q <= 1'b1;
      done_q     <= 1'b0;
      pend_q     <= 1'b0;
      end_q      <= 1'b0;
      fch_q      <= '0;
      fb_q       <= 1'b0;
      icyc_q     <= 1'b0;
      lat_q      <= '0;
      for (int c = 0; c < CH; c++) begin
        a_q[c] <= '0;
        b_q[c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      addr_q     <= addr_d;
      out_q      <= out_d;
      step_q     <= step_d;
      interp_q   <= interp_d;
      reverse_q  <= reverse_d;
      loop_q     <= loop_d;
      lrck_q     <= i_daclrck;
      is_pause_q <= is_pause_d;
      done_q     <= done_d;
      pend_q     <= pend_d;
      end_q      <= end_d;
      fch_q      <= fch_d;
      fb_q       <= fb_d;
      icyc_q     <= icyc_d;
      lat_q      <= lat_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_lerp
    aud_lerp #(
      .SAMPLE_W (SAMPLE_W),
      .FRAC_W   (FRAC_W)
    ) u_lerp (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .a_i      (a_q[g]),
      .b_i      (b_q[g]),
      .frac_i   (phase_q[FRAC_W-1:0]),
      .hold_i   (!interp_q),
      .sample_o (lerp_out[g])
    );
  end

  assign o_sram_addr = addr_q;
  assign o_dac_data  = out_q;
  assign o_en        = !i_daclrck;
  assign o_is_pause  = is_pause_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_done      = done_q;

endmodule

// File: tb/tb_aud_resampler.sv
module tb_aud_resampler;
  import aud_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, pause_p = 1'b0;
  logic [10:0] step = 11'd0;
  logic        interp = 1'b0, reverse = 1'b0, loop_m = 1'b0;
  logic        lrck = 1'b0;
  logic [15:0] sram_data = 16'd0;
  logic [19:0] start_addr = 20'd0, stop_addr = 20'd7;
  logic [19:0] sram_addr;
  logic [31:0] dac;
  logic        en, is_pause, busy, done;

  logic [15:0] mem [0:63];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  logic [31:0] last_seen = 32'd0;
  logic        unused_tb;

  always #5 clk = ~clk;

  aud_resampler dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .i_pause(pause_p), .i_step(step), .i_interp(interp), .i_reverse(reverse),
    .i_loop(loop_m), .i_daclrck(lrck), .i_sram_data(sram_data),
    .i_start_addr(start_addr), .i_stop_addr(stop_addr),
    .o_sram_addr(sram_addr), .o_dac_data(dac), .o_en(en),
    .o_is_pause(is_pause), .o_busy(busy), .o_done(done)
  );

  assign unused_tb = ^{sram_addr[19:6], en};

  // one-cycle SRAM
  always @(posedge clk) sram_data <= mem[sram_addr[5:0]];

  // observers: done-high cycles, most recent non-zero output
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (dac != 32'd0) last_seen <= dac;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_pause();
    @(posedge clk); #1 pause_p = 1'b1;
    @(posedge clk); #1 pause_p = 1'b0;
  endtask

  task automatic do_frame(output logic [31:0] d);
    @(posedge clk); #1 lrck = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk); d = dac;
    @(posedge clk); #1 lrck = 1'b0;
    repeat (20) @(posedge clk);
  endtask

  task automatic setup(input logic [19:0] sa, input logic [19:0] ea, input logic [10:0] st,
                       input logic ip, input logic rv, input logic lp);
    start_addr = sa; stop_addr = ea; step = st; interp = ip; reverse = rv; loop_m = lp;
    pulse_start();
    pulse_pause();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (sram_addr !== 20'd0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", sram_addr); end
    n_cmp++; if (dac !== 32'd0) begin n_bad++; $display("FAIL rst_dac: got %h want 0", dac); end
    n_cmp++; if (is_pause !== 1'b1) begin n_bad++; $display("FAIL rst_pause: got %b want 1", is_pause); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_hold_loop();
    logic [31:0] exp_t [5] = '{32'h0014_000A, 32'h0028_001E, 32'h003C_0032, 32'h0050_0046, 32'h0014_000A};
    logic [31:0] d;
    setup(20'd0, 20'd7, 11'(one_q(8)), 1'b0, 1'b0, 1'b1);
    n_cmp++; if (is_pause !== 1'b0) begin n_bad++; $display("FAIL hold_run: got %b want 0", is_pause); end
    for (int i = 0; i < 5; i++) begin
      do_frame(d);
      n_cmp++; if (d !== exp_t[i]) begin n_bad++; $display("FAIL hold_f%0d: got %h want %h", i, d, exp_t[i]); end
    end
  endtask

  task automatic test_lerp();
    logic [31:0] exp_p [3] = '{{16'd7, 16'd100}, {16'd7, 16'd150}, {16'd7, 16'd200}};
    logic [31:0] exp_n [3] = '{{16'd0, 16'hFF9C}, 32'd0, {16'd0, 16'd101}};
    logic [31:0] d;
    setup(20'd16, 20'd19, 11'h080, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_frame(d);
      n_cmp++; if (d !== exp_p[i]) begin n_bad++; $display("FAIL lerp_pos%0d: got %h want %h", i, d, exp_p[i]); end
    end
    setup(20'd24, 20'd27, 11'h080, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_frame(d);
      n_cmp++; if (d !== exp_n[i]) begin n_bad++; $display("FAIL lerp_neg%0d: got %h want %h", i, d, exp_n[i]); end
    end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL lerp_busy: got %b want 1", busy); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    int d0;
    setup(20'd0, 20'd7, 11'h200, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    do_frame(d);
    n_cmp++; if (d !== 32'h0014_000A) begin n_bad++; $display("FAIL shot_f0: got %h want 0014000a", d); end
    n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL shot_early_done: got %0d want %0d", done_cnt, d0); end
    do_frame(d);
    n_cmp++; if (last_seen !== 32'h003C_0032) begin n_bad++; $display("FAIL shot_f2: got %h want 003c0032", last_seen); end
    n_cmp++; if (done_cnt !== d0 + 1) begin n_bad++; $display("FAIL shot_done_cycles: got %0d want %0d", done_cnt, d0 + 1); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL shot_busy: got %b want 0", busy); end
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL shot_dac: got %h want 0", d); end
  endtask

  task automatic test_step_zero();
    logic [31:0] d;
    int d0;
    setup(20'd0, 20'd7, 11'd0, 1'b0, 1'b0, 1'b0);
    d0 = done_cnt;
    for (int i = 0; i < 2; i++) begin
      do_frame(d);
      n_cmp++; if (d !== 32'h0014_000A) begin n_bad++; $display("FAIL step0_f%0d: got %h want 0014000a", i, d); end
    end
    n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL step0_done: got %0d want %0d", done_cnt, d0); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL step0_busy: got %b want 1", busy); end
  endtask

  task automatic test_reverse();
    logic [31:0] exp_t [5] = '{32'h0014_000A, 32'h0050_0046, 32'h003C_0032, 32'h0028_001E, 32'h0014_000A};
    logic [31:0] d;
    setup(20'd0, 20'd7, 11'h100, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      do_frame(d);
      n_cmp++; if (d !== exp_t[i]) begin n_bad++; $display("FAIL rev_f%0d: got %h want %h", i, d, exp_t[i]); end
    end
  endtask

  task automatic test_pause_mid_fetch();
    logic [31:0] d;
    setup(20'd0, 20'd7, 11'h100, 1'b0, 1'b0, 1'b1);
    do_frame(d);
    n_cmp++; if (d !== 32'h0014_000A) begin n_bad++; $display("FAIL pz_f0: got %h want 0014000a", d); end
    @(posedge clk); #1 lrck = 1'b1;
    repeat (3) @(posedge clk);
    #1 pause_p = 1'b1;
    @(posedge clk); #1 pause_p = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (last_seen !== 32'h0028_001E) begin n_bad++; $display("FAIL pz_completed: got %h want 0028001e", last_seen); end
    n_cmp++; if (is_pause !== 1'b1) begin n_bad++; $display("FAIL pz_flag: got %b want 1", is_pause); end
    n_cmp++; if (dac !== 32'd0) begin n_bad++; $display("FAIL pz_mute: got %h want 0", dac); end
    @(posedge clk); #1 lrck = 1'b0;
    repeat (20) @(posedge clk);
    do_frame(d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL pz_held: got %h want 0", d); end
    pulse_pause();
    do_frame(d);
    n_cmp++; if (d !== 32'h003C_0032) begin n_bad++; $display("FAIL pz_resume: got %h want 003c0032", d); end
  endtask

  task automatic test_stop_pause();
    logic [31:0] d;
    @(posedge clk); #1 stop = 1'b1; pause_p = 1'b1;
    @(posedge clk); #1 stop = 1'b0; pause_p = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b want 0", busy); end
    n_cmp++; if (is_pause !== 1'b1) begin n_bad++; $display("FAIL stop_pause: got %b want 1", is_pause); end
    n_cmp++; if (dac !== 32'd0) begin n_bad++; $display("FAIL stop_dac: got %h want 0", dac); end
    do_frame(d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL stop_idle_frame: got %h want 0", d); end
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] d;
    setup(20'd16, 20'd19, 11'h100, 1'b0, 1'b0, 1'b1);
    do_frame(d);
    n_cmp++; if (d !== {16'd7, 16'd100}) begin n_bad++; $display("FAIL rmf_f0: got %h want 00070064", d); end
    @(posedge clk); #1 lrck = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (sram_addr !== 20'd0) begin n_bad++; $display("FAIL rmf_addr: got %h want 0", sram_addr); end
    n_cmp++; if (dac !== 32'd0) begin n_bad++; $display("FAIL rmf_dac: got %h want 0", dac); end
    n_cmp++; if (is_pause !== 1'b1) begin n_bad++; $display("FAIL rmf_pause: got %b want 1", is_pause); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmf_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rmf_done: got %b want 0", done); end
    @(posedge clk); #1 rst_n = 1'b1; lrck = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'd0;
    for (int i = 0; i < 8; i++) mem[i] = 16'(10 * (i + 1));
    mem[16] = 16'd100; mem[17] = 16'd7; mem[18] = 16'd200; mem[19] = 16'd7;
    mem[24] = 16'hFF9C; mem[25] = 16'd0; mem[26] = 16'd101; mem[27] = 16'd0;
    test_reset();
    test_hold_loop();
    test_lerp();
    test_oneshot();
    test_step_zero();
    test_reverse();
    test_pause_mid_fetch();
    test_stop_pause();
    test_reset_mid_fetch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aud_resampler.md
Name: aud_resampler

Overview:
- Parametrised N-channel playback DSP between the SRAM reader and AudPlayer.
- Fetches interleaved frames from SRAM, steps through them with a fractional phase accumulator (any rate, forward or reverse), and produces one sample per channel per frame.
- Each sample uses either hold or linear interpolation.
- Supports pause with mute, loop or one-shot end, and a start/stop address window.

Parameters:
- SAMPLE_W, 16, sample width (signed two's complement)
- ADDR_W, 20, SRAM word address width
- CH, 2, channels per frame, interleaved ch0..ch(CH-1) at consecutive addresses
- FRAC_W, 8, fractional bits of step and phase
- INT_W, 3, integer bits of step (max step < 2^INT_W)
- SRAM_LAT, 1, cycles from o_sram_addr change to valid i_sram_data

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  pulse: (re)start playback at i_start_addr, paused
- i_stop  in  1  pulse: abort to IDLE
- i_pause  in  1  pulse: toggle pause/run
- i_step  in  INT_W+FRAC_W  unsigned playback rate, Q(INT_W.FRAC_W); 1.0 = 1<<FRAC_W
- i_interp  in  1  0 = hold, 1 = linear
- i_reverse  in  1  1 = phase decrements
- i_loop  in  1  1 = wrap at window edge, 0 = one-shot
- i_daclrck  in  1  DAC LR clock; a rising edge marks the frame boundary
- i_sram_data  in  SAMPLE_W  SRAM read data
- i_start_addr  in  ADDR_W  first word of window
- i_stop_addr  in  ADDR_W  last word of window, inclusive
- o_sram_addr  out  ADDR_W  SRAM read address
- o_dac_data  out  CH*SAMPLE_W  ch0 in LSBs
- o_en  out  1  = !i_daclrck
- o_is_pause  out  1  paused flag
- o_busy  out  1  state != IDLE
- o_done  out  1  one-cycle pulse at one-shot end

Behaviour:
- Reset values: o_sram_addr 0, o_dac_data 0, o_is_pause 1, o_busy 0, o_done 0. Internal: phase 0, state IDLE.
- Window geometry:
  - NFRAMES = (i_stop_addr - i_start_addr + 1)/CH. Window alignment to CH is the caller's duty.
  - phase is unsigned, ADDR_W+FRAC_W wide, in frames relative to the window; idx = phase>>FRAC_W, frac = low FRAC_W bits.
  - Address for frame f, channel c = i_start_addr + f*CH + c.
- States:
  - IDLE: i_start -> PAUSE with phase 0.
  - PAUSE: o_dac_data is forced to 0 (mute). An i_pause pulse clears o_is_pause and moves to WAIT_LR.
  - WAIT_LR: a daclrck rising edge (registered previous value 0, current 1) latches i_step, i_interp, i_reverse, i_loop and moves to FETCH. An i_pause pulse sets o_is_pause and moves to PAUSE.
  - FETCH: per channel c, read A = frame idx and B = frame idx+1. B = A when idx = NFRAMES-1 or when i_interp = 0. Each read holds the address SRAM_LAT+1 cycles and captures on the last. Then -> INTERP.
  - INTERP: one registered lerp stage, then all CH outputs update in one cycle, then the phase advances and -> WAIT_LR.
- Lerp arithmetic:
  - out = A + (((B-A)*frac) >>> FRAC_W).
  - Diff is SAMPLE_W+1 bits, product SAMPLE_W+FRAC_W+2 bits, arithmetic shift (floor).
  - The result always lies in [min(A,B), max(A,B)], so no saturation is needed.
  - Hold mode: out = A.
- Latency: daclrck rising edge to o_dac_data update = 1 + 2*CH*(SRAM_LAT+1) + 1 cycles, which must be below the daclrck high time.
- Phase advance and window ends:
  - Forward: phase += step. If the new idx >= NFRAMES: loop -> phase -= NFRAMES<<FRAC_W (keep frac); one-shot -> o_done pulse, IDLE, o_dac_data 0.
  - Reverse: phase -= step. Underflow below 0: loop -> phase += NFRAMES<<FRAC_W; one-shot -> done as above.
- step = 0: the output freezes on the current frame (legal, no done).
- Pause timing: i_pause during FETCH/INTERP is registered and applied on the return to WAIT_LR; that frame still completes. Resume continues from the held phase.
- Priority in any state: i_stop > i_start > i_pause.
  - i_stop -> IDLE, outputs 0, o_is_pause 1.
  - i_start while busy -> PAUSE, phase 0.
- Reset mid-operation returns all registers to their reset values immediately.

Decomposition:
- Package aud_pkg: state enum (IDLE, PAUSE, WAIT_LR, FETCH, INTERP), ONE_Q = 1<<FRAC_W helper, width localparams.
- Sub-module aud_lerp: parametrised SAMPLE_W/FRAC_W, one registered stage, inputs A, B, frac, hold, output sample.

Test Plan:
- Reset, then i_start, i_pause, step 0x100, CH=2, window 0..7 with data 10,20,30,...: frames out (10,20),(30,40),(50,60),(70,80); loop=1 wraps to (10,20).
- step 0x080, linear, ch0 A=100, B=200: outputs 100, 150, 200. Same with A=-100, B=101: 0.5 point = 0 (floor).
- step 0x200, one-shot, NFRAMES=4: frames 0, 2, then o_done pulse for one cycle, o_busy 0, o_dac_data 0.
- Reverse, step 0x100, loop, start phase 0: frames 0, 3, 2, 1, 0.
- i_pause mid-FETCH: the current frame completes, then o_is_pause 1 and output 0. A second i_pause resumes at the next frame index with no skip.
- i_stop and i_pause in the same cycle during WAIT_LR: IDLE, o_is_pause 1; reset asserted mid-FETCH gives all outputs at their reset values at once.
